// File: rtl/level_map_ram_if.sv
// rtl/level_map_ram_if.sv - Avalon-MM CPU tile port bundle for the live level map
interface level_map_ram_if;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [8:0]  avs_address;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_chipselect, avs_read, avs_write, avs_address, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_chipselect, avs_read, avs_write, avs_address, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/level_map_ram.sv
// rtl/level_map_ram.sv - live room tile map: row-by-row room load, CPU tile access, per-pixel wall lookup
module level_map_ram #(
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int ROOMS = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load_req,
  input  logic [2:0]       load_room,
  output logic [8:0]       src_row_idx,
  input  logic [COLS-1:0]  src_row_data,
  output logic             busy,
  output logic             done,
  level_map_ram_if.slave   avs,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic             bg_type
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [4:0]    ROWS_L   = 5'(ROWS);
  localparam logic [4:0]    COLS_L   = 5'(COLS);
  localparam logic [3:0]    ROOMS_L  = 4'(ROOMS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_LOAD = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [2:0]               room_q, room_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     done_q, done_d;
  logic [8:0]               idx_q;
  logic [31:0]              readdata_q;
  logic [ROWS-1:0][COLS-1:0] map_q;

  logic       idle;
  logic       load_accept;
  logic [8:0] cur_idx;
  logic [4:0] cpu_row, cpu_col;
  logic       cpu_in_range;
  logic       cpu_tile;
  logic [4:0] draw_row, draw_col;
  logic       unused_bits;

  assign idle        = (state_q == STATE_IDLE);
  assign load_accept = idle && load_req && ({1'b0, load_room} < ROOMS_L);
  assign cur_idx     = 9'(ROWS) * 9'(room_q) + 9'(row_q);

  // Outside a load the source index parks on the last row fetched.
  assign src_row_idx = idle ? idx_q : cur_idx;
  assign busy        = ~idle;
  assign done        = done_q;

  assign cpu_row      = {1'b0, avs.avs_address[8:5]};
  assign cpu_col      = avs.avs_address[4:0];
  assign cpu_in_range = (cpu_row < ROWS_L) && (cpu_col < COLS_L);
  assign cpu_tile     = cpu_in_range && map_q[cpu_row[RW-1:0]][cpu_col[CW-1:0]];

  assign avs.avs_waitrequest = avs.avs_chipselect && (avs.avs_read || avs.avs_write) && !idle;
  assign avs.avs_readdata    = readdata_q;

  assign draw_row = DrawY[9:5];
  assign draw_col = DrawX[9:5];

  assign unused_bits = ^{avs.avs_writedata[31:1], DrawX[4:0], DrawY[4:0]};

  // Floor is shown everywhere while a load rewrites the map.
  always_comb begin
    bg_type = 1'b0;
    if (idle && (draw_row < ROWS_L) && (draw_col < COLS_L)) begin
      bg_type = map_q[draw_row[RW-1:0]][draw_col[CW-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    room_d  = room_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (load_accept) begin
          state_d = STATE_LOAD;
          room_d  = load_room;
          row_d   = '0;
        end
      end
      STATE_LOAD: begin
        row_d = row_q + RW'(1);
        if (row_q == ROW_LAST) begin
          state_d = STATE_IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= STATE_IDLE;
      room_q     <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      readdata_q <= '0;
      map_q      <= '0;
    end else begin
      state_q <= state_d;
      room_q  <= room_d;
      row_q   <= row_d;
      done_q  <= done_d;
      idx_q   <= src_row_idx;
      // A CPU write on the accepting edge lands first; the load overwrites it later.
      if (!idle) begin
        map_q[row_q] <= src_row_data;
      end else if (avs.avs_chipselect && avs.avs_write && cpu_in_range) begin
        map_q[cpu_row[RW-1:0]][cpu_col[CW-1:0]] <= avs.avs_writedata[0];
      end
      if (idle && avs.avs_chipselect && avs.avs_read) begin
        readdata_q <= {31'd0, cpu_tile};
      end
    end
  end

endmodule

// File: tb/tb_level_map_ram.sv
// tb/tb_level_map_ram.sv - scoreboard bench for level_map_ram
module tb_level_map_ram;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        load_req;
  logic [2:0]  load_room;
  logic [8:0]  src_row_idx;
  logic [19:0] src_row_data;
  logic        busy, done, bg_type;
  logic [9:0]  DrawX, DrawY;

  level_map_ram_if bus ();

  level_map_ram dut (
    .Clk(Clk), .Reset_n(Reset_n), .load_req(load_req), .load_room(load_room),
    .src_row_idx(src_row_idx), .src_row_data(src_row_data), .busy(busy), .done(done),
    .avs(bus), .DrawX(DrawX), .DrawY(DrawY), .bg_type(bg_type)
  );

  always #5 Clk = ~Clk;

  logic [19:0] rom [0:29];
  always_comb begin
    src_row_data = '0;
    if (src_row_idx < 9'd30) src_row_data = rom[src_row_idx];
  end

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t pr_q[$];
  chk_t rd_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  logic rd_fire  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge Clk)
    rd_fire <= Reset_n && bus.avs_chipselect && bus.avs_read && !bus.avs_waitrequest;

  // Monitor: tallies DUT pulses, then retires read results and sampled probes.
  always @(negedge Clk) begin
    chk_t        c;
    logic [31:0] act;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (rd_fire) begin
      if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
      else begin
        c = rd_q.pop_front();
        check(c.name, bus.avs_readdata, c.exp);
      end
    end
    while (pr_q.size() > 0) begin
      c = pr_q.pop_front();
      case (c.kind)
        0:       act = {31'd0, bg_type};
        1:       act = {31'd0, busy};
        2:       act = {31'd0, done};
        3:       act = {23'd0, src_row_idx};
        4:       act = {31'd0, bus.avs_waitrequest};
        5:       act = done_cnt;
        6:       act = busy_cnt;
        default: act = bus.avs_readdata;
      endcase
      check(c.name, act, c.exp);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic probe(input string n, input int k, input logic [31:0] e);
    chk_t c;
    c.name = n; c.kind = k; c.exp = e;
    pr_q.push_back(c);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic d);
    bus.avs_chipselect = 1'b1; bus.avs_write = 1'b1;
    bus.avs_address = a; bus.avs_writedata = {31'd0, d};
    tick();
    bus.avs_chipselect = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic cpu_read(input string n, input logic [8:0] a, input logic e);
    chk_t c;
    c.name = n; c.kind = 7; c.exp = {31'd0, e};
    rd_q.push_back(c);
    bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_address = a;
    tick();
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0;
  endtask

  task automatic draw(input string n, input int x, input int y, input logic e);
    DrawX = 10'(x); DrawY = 10'(y);
    probe(n, 0, {31'd0, e});
    tick();
  endtask

  task automatic run_load(input logic [2:0] room, input int base, input bit hold);
    DrawX = '0; DrawY = '0;
    load_room = room; load_req = 1'b1;
    tick();
    if (!hold) load_req = 1'b0;
    for (int r = 0; r < 15; r++) begin
      probe("load_busy", 1, 32'd1);
      probe("load_idx", 3, 32'(base + r));
      probe("load_blank", 0, 32'd0);
      tick();
    end
    load_req = 1'b0;
    probe("done_pulse", 2, 32'd1);
    probe("busy_after", 1, 32'd0);
    probe("idx_hold", 3, 32'(base + 14));
    tick();
    probe("done_single", 2, 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 30; i++) rom[i] = '0;
    rom[0]  = 20'hFFFFF;
    rom[5]  = 20'h04000;
    rom[15] = 20'hFFFFF;
    rom[16] = 20'h00001;
    rom[17] = 20'hFFFFD;
    rom[22] = 20'h00200;

    Reset_n = 1'b0; load_req = 1'b0; load_room = '0;
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_address = '0; bus.avs_writedata = '0;
    DrawX = '0; DrawY = '0;

    probe("rst_busy", 1, 32'd0);
    probe("rst_done", 2, 32'd0);
    probe("rst_idx", 3, 32'd0);
    probe("rst_wait", 4, 32'd0);
    probe("rst_rdata", 7, 32'd0);
    probe("rst_bg", 0, 32'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    run_load(3'd0, 0, 1'b0);
    cpu_read("r0_row5_col14", 9'h0AE, 1'b1);
    cpu_read("r0_row5_col13", 9'h0AD, 1'b0);
    draw("r0_bg_row5_col14", 448, 160, 1'b1);

    run_load(3'd1, 15, 1'b1);
    draw("r1_bg_300_230", 300, 230, 1'b1);
    draw("r1_bg_40_70", 40, 70, 1'b0);
    cpu_read("r1_row5_col14", 9'h0AE, 1'b0);
    draw("bg_x600", 600, 0, 1'b1);
    draw("bg_x700", 700, 0, 1'b0);
    draw("bg_y480", 0, 480, 1'b0);

    draw("bg_row1_before", 0, 32, 1'b1);
    cpu_write(9'h020, 1'b0);
    draw("bg_row1_after", 0, 32, 1'b0);
    cpu_write(9'h1E3, 1'b1);
    cpu_read("oob_row15_col3", 9'h1E3, 1'b0);
    cpu_read("oob_col25", 9'd89, 1'b0);
    cpu_read("row2_col5", 9'd69, 1'b1);

    DrawX = '0; DrawY = '0;
    load_room = 3'd0; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick(); tick(); tick();
    bus.avs_chipselect = 1'b1; bus.avs_write = 1'b1;
    bus.avs_address = 9'h003; bus.avs_writedata = 32'd0;
    for (int r = 3; r < 15; r++) begin
      probe("stall_wait", 4, 32'd1);
      probe("stall_blank", 0, 32'd0);
      tick();
    end
    probe("stall_release", 4, 32'd0);
    probe("stall_done", 2, 32'd1);
    tick();
    bus.avs_chipselect = 1'b0; bus.avs_write = 1'b0;
    cpu_read("stalled_write", 9'h003, 1'b0);
    cpu_read("row0_col4", 9'h004, 1'b1);
    draw("bg_row0_after", 0, 0, 1'b1);

    load_room = 3'd5; load_req = 1'b1;
    tick();
    probe("bad_room_busy", 1, 32'd0);
    tick();
    load_req = 1'b0;
    probe("bad_room_busy2", 1, 32'd0);
    probe("bad_room_done", 2, 32'd0);
    tick();
    probe("busy_cycles", 6, 32'd45);
    probe("done_count", 5, 32'd3);
    tick();

    load_room = 3'd1; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick(); tick(); tick(); tick();
    Reset_n = 1'b0;
    probe("abort_busy", 1, 32'd0);
    probe("abort_idx", 3, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    probe("abort_no_done", 2, 32'd0);
    tick();
    probe("abort_no_done2", 2, 32'd0);
    probe("abort_done_count", 5, 32'd3);
    tick();
    cpu_read("abort_map_clear", 9'h004, 1'b0);
    draw("abort_bg", 0, 0, 1'b0);
    tick();
    tick();

    check("queues_drained", 32'(pr_q.size() + rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
